// File: rtl/overlay_mix_ctrl.sv
// Overlay sequencer: alpha-blends a 128x128 ROM logo into a window
// of the 256x256 RAM picture, writing each result back in place.
module overlay_mix_ctrl #(
  parameter int unsigned X_OFF = 64,
  parameter int unsigned Y_OFF = 64,
  parameter int unsigned ALPHA = 8,
  parameter logic [23:0] KEY_COLOR = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] ROM_Q,
  input  logic [23:0] RAM_Q,
  output logic [13:0] ROM_A,
  output logic        ROM_OE,
  output logic [15:0] RAM_A,
  output logic        RAM_WE,
  output logic        RAM_OE,
  output logic [23:0] RAM_D,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [15:0] XO = 16'(X_OFF);
  localparam logic [15:0] YO = 16'(Y_OFF);
  localparam logic [11:0] WL = 12'(ALPHA);
  localparam logic [11:0] WB = 12'(16 - ALPHA);

  state_t     state;
  logic [6:0] x, y;
  logic [6:0] nx, ny;
  logic       last;
  logic       keyed;
  logic       adv;

  function automatic logic [15:0] ram_addr(
    input logic [6:0] px,
    input logic [6:0] py
  );
    return ((YO + {9'd0, py}) << 8) + XO + {9'd0, px};
  endfunction

  // Truncating blend: 12-bit products, 13-bit sum, drop 4 LSBs.
  function automatic logic [7:0] mix(
    input logic [7:0] l,
    input logic [7:0] b
  );
    logic [11:0] pl, pb;
    logic [12:0] s;
    pl = {4'd0, l} * WL;
    pb = {4'd0, b} * WB;
    s  = {1'b0, pl} + {1'b0, pb};
    return 8'(s >> 4);
  endfunction

  always_comb begin
    nx    = x + 7'd1;
    ny    = (x == 7'd127) ? y + 7'd1 : y;
    last  = (x == 7'd127) && (y == 7'd127);
    keyed = (ROM_Q == KEY_COLOR);
    adv   = (state == S_WR) || ((state == S_WAIT) && keyed);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      x      <= '0;
      y      <= '0;
      ROM_A  <= '0;
      RAM_A  <= '0;
      ROM_OE <= 1'b0;
      RAM_OE <= 1'b0;
      RAM_WE <= 1'b0;
      RAM_D  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RD;
            done   <= 1'b0;
            busy   <= 1'b1;
            ROM_OE <= 1'b1;
            RAM_OE <= 1'b1;
            ROM_A  <= {y, x};
            RAM_A  <= ram_addr(x, y);
          end
        end
        S_RD: begin
          state  <= S_WAIT;
          ROM_OE <= 1'b0;
          RAM_OE <= 1'b0;
        end
        S_WAIT: begin
          if (!keyed) begin
            state  <= S_WR;
            RAM_WE <= 1'b1;
            RAM_D  <= {mix(ROM_Q[23:16], RAM_Q[23:16]),
                       mix(ROM_Q[15:8], RAM_Q[15:8]),
                       mix(ROM_Q[7:0], RAM_Q[7:0])};
          end
        end
        S_WR: begin
          RAM_WE <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Step to the next pixel; the counter wraps to 0,0 after the last.
      if (adv) begin
        x <= nx;
        y <= ny;
        if (last) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state  <= S_RD;
          ROM_OE <= 1'b1;
          RAM_OE <= 1'b1;
          ROM_A  <= {ny, nx};
          RAM_A  <= ram_addr(nx, ny);
        end
      end
    end
  end

endmodule

// File: tb/tb_overlay_mix_ctrl.sv
// Scoreboard bench: three controller instances with different window
// offsets and alpha, each with its own behavioural ROM/RAM.
module tb_overlay_mix_ctrl;
  localparam int NL = 3;
  localparam int NPIX = 16384;
  localparam int unsigned XO[NL] = '{64, 128, 0};
  localparam int unsigned YO[NL] = '{64, 0, 128};
  localparam int unsigned AL[NL] = '{8, 16, 0};
  localparam logic [23:0] KEY = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [NL];
  logic [23:0] rom_q [NL];
  logic [23:0] ram_q [NL];
  logic [23:0] ram_d [NL];
  logic [13:0] rom_a [NL];
  logic [15:0] ram_a [NL];
  logic        rom_oe[NL];
  logic        ram_oe[NL];
  logic        ram_we[NL];
  logic        busy  [NL];
  logic        done  [NL];

  logic [23:0] rom [NL][NPIX];
  logic [23:0] ram [NL][65536];
  logic [23:0] mram[NL][65536];
  logic [39:0] exp_q[NL][$];

  int errors = 0;
  int checks = 0;
  int busy_cnt [NL] = '{0, 0, 0};
  int done_rise[NL] = '{0, 0, 0};
  logic [15:0] last_wa[NL] = '{16'd0, 16'd0, 16'd0};
  bit   prev_we  [NL] = '{0, 0, 0};
  bit   prev_done[NL] = '{0, 0, 0};
  logic [15:0] prev_a[NL] = '{16'd0, 16'd0, 16'd0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    overlay_mix_ctrl #(
      .X_OFF(XO[g]),
      .Y_OFF(YO[g]),
      .ALPHA(AL[g]),
      .KEY_COLOR(KEY)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start[g]),
      .ROM_Q(rom_q[g]),
      .RAM_Q(ram_q[g]),
      .ROM_A(rom_a[g]),
      .ROM_OE(rom_oe[g]),
      .RAM_A(ram_a[g]),
      .RAM_WE(ram_we[g]),
      .RAM_OE(ram_oe[g]),
      .RAM_D(ram_d[g]),
      .busy(busy[g]),
      .done(done[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_mix(input logic [23:0] l,
                                          input logic [23:0] b,
                                          input int unsigned al);
    logic [23:0] r;
    int lc, bc;
    for (int c = 0; c < 3; c++) begin
      lc = int'(l[c*8 +: 8]);
      bc = int'(b[c*8 +: 8]);
      r[c*8 +: 8] = 8'((lc * int'(al) + bc * (16 - int'(al))) / 16);
    end
    return r;
  endfunction

  function automatic int ref_addr(input int ln, input int p);
    return (int'(YO[ln]) + p / 128) * 256 + int'(XO[ln]) + p % 128;
  endfunction

  // Expected write stream and busy length for the first npix pixels.
  task automatic plan(input int ln, input int npix, output int cyc);
    int a;
    logic [23:0] d;
    cyc = 0;
    for (int p = 0; p < npix; p++) begin
      a = ref_addr(ln, p);
      if (rom[ln][p] == KEY) begin
        cyc += 2;
      end else begin
        d = ref_mix(rom[ln][p], mram[ln][a], AL[ln]);
        mram[ln][a] = d;
        exp_q[ln].push_back({16'(a), d});
        cyc += 3;
      end
    end
  endtask

  task automatic fill(input int ln, input int keypct);
    for (int p = 0; p < NPIX; p++) begin
      rom[ln][p] = 24'($urandom);
      if (int'($urandom_range(99)) < keypct) rom[ln][p] = KEY;
      else if (rom[ln][p] == KEY) rom[ln][p] = 24'h0;
    end
    rom[ln][NPIX-1] = 24'h808080;
    for (int a = 0; a < 65536; a++) begin
      ram[ln][a] = 24'($urandom);
      mram[ln][a] = ram[ln][a];
    end
  endtask

  // Synchronous memories: Q valid the cycle after OE is sampled.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NL; i++) begin
      if (rom_oe[i] === 1'b1) rom_q[i] <= rom[i][rom_a[i]];
      if (ram_oe[i] === 1'b1) ram_q[i] <= ram[i][ram_a[i]];
      if (ram_we[i] === 1'b1) ram[i][ram_a[i]] <= ram_d[i];
    end
  end

  // Monitor: pops the scoreboard on every observed RAM write.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      if (ram_we[i] === 1'b1) begin
        chk("oe_we_exclusive", {rom_oe[i], ram_oe[i]}, 2'b00);
        chk("write_expected", exp_q[i].size() > 0, 1);
        if (exp_q[i].size() > 0)
          chk("write_addr_data", {ram_a[i], ram_d[i]},
              exp_q[i].pop_front());
        last_wa[i] = ram_a[i];
      end
      if (done[i] === 1'b1 && !prev_done[i]) begin
        done_rise[i]++;
        chk("done_after_last_write", {prev_we[i], prev_a[i]},
            {1'b1, 16'(ref_addr(i, NPIX - 1))});
      end
      if (busy[i] === 1'b1) busy_cnt[i]++;
      prev_done[i] = (done[i] === 1'b1);
      prev_we[i]   = (ram_we[i] === 1'b1);
      prev_a[i]    = ram_a[i];
    end
  end

  initial begin
    int b0[NL];
    int cyc[NL];
    int n;
    int bad;
    int cdummy;
    bit ok;

    rst = 1'b0;
    for (int i = 0; i < NL; i++) start[i] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NL; i++)
      chk("reset_outputs", {rom_a[i], ram_a[i], ram_d[i], rom_oe[i],
          ram_oe[i], ram_we[i], busy[i], done[i]}, 64'd0);
    rst = 1'b1;
    for (int i = 0; i < NL; i++) start[i] = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++)
        if (rom_oe[i] || ram_oe[i] || ram_we[i] || busy[i]) ok = 1'b0;
    end
    chk("idle_quiet", ok, 1);

    fill(0, 12);
    fill(1, 0);
    fill(2, 12);
    rom[0][0] = 24'h204060;
    ram[0][16448] = 24'h000000;
    mram[0][16448] = 24'h000000;
    rom[0][1] = KEY;
    ram[0][16449] = 24'h123456;
    mram[0][16449] = 24'h123456;
    rom[0][100] = 24'h0A0B0C;
    for (int i = 0; i < NL; i++) begin
      plan(i, NPIX, cyc[i]);
      b0[i] = busy_cnt[i];
    end

    @(negedge clk);
    for (int i = 0; i < NL; i++) start[i] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) start[i] = 1'b0;
    @(negedge clk);
    chk("rd0_lane0", {rom_oe[0], ram_oe[0], busy[0], rom_a[0], ram_a[0]},
        {1'b1, 1'b1, 1'b1, 14'd0, 16'd16448});
    chk("rd0_lane1_addr", ram_a[1], 16'd128);
    chk("rd0_lane2_addr", ram_a[2], 16'd32768);
    @(negedge clk);
    chk("wait_quiet", {rom_oe[0], ram_oe[0], ram_we[0]}, 3'b000);
    @(negedge clk);
    chk("wr0", {ram_we[0], ram_a[0], ram_d[0]},
        {1'b1, 16'd16448, 24'h102030});
    repeat (3) @(negedge clk);
    chk("rd2_after_key", {rom_oe[0], rom_a[0]}, {1'b1, 14'd2});

    n = 0;
    while (!(rom_oe[0] && rom_a[0] == 14'd50) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_px50", n < 1000, 1);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;

    n = 0;
    while (!(done[0] && done[1] && done[2]) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", n < 60000, 1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      chk("busy_cycles", busy_cnt[i] - b0[i], cyc[i]);
      chk("done_held_once", {done[i], 32'(done_rise[i])}, {1'b1, 32'd1});
      chk("queue_drained", exp_q[i].size(), 0);
    end
    chk("busy_no_keys", busy_cnt[1] - b0[1], 49152);
    chk("last_write", last_wa[0], 16'd49087);
    chk("keyed_untouched", ram[0][16449], 24'h123456);

    plan(0, 100, cdummy);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_cleared", {done[0], busy[0]}, 2'b01);
    start[0] = 1'b0;
    n = 0;
    while (!(rom_oe[0] && rom_a[0] == 14'd100) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_px100", n < 2000, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {rom_a[0], ram_a[0], ram_d[0], rom_oe[0],
        ram_oe[0], ram_we[0], busy[0], done[0]}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_queue", exp_q[0].size(), 0);
    chk("abort_nowrite", ram[0][ref_addr(0, 100)],
        mram[0][ref_addr(0, 100)]);

    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(negedge clk);
    chk("restart_rd0", {rom_oe[0], ram_oe[0], rom_a[0], ram_a[0]},
        {1'b1, 1'b1, 14'd0, 16'd16448});
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NL; i++) begin
      bad = 0;
      for (int a = 0; a < 65536; a++)
        if (ram[i][a] !== mram[i][a]) bad++;
      chk("final_image", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/overlay_mix_ctrl.md
Name: overlay_mix_ctrl

Overview:
Sequencer that overlays the 128x128 24-bit logo held in the ROM onto a window of the 256x256 24-bit picture held in the RAM.
- Per pixel: reads both memories, alpha-blends per colour channel, writes the result back to the RAM in place.
- Pixels equal to a key colour are transparent and are not written.
- Sits between the ROM/RAM macros and the system top; drives every memory control pin and reports completion.

Parameters:
X_OFF, 64, window column offset in the RAM picture; legal range 0..128.
Y_OFF, 64, window row offset in the RAM picture; legal range 0..128.
ALPHA, 8, logo weight in sixteenths; legal range 0..16.
KEY_COLOR, 24'hFFFFFF, logo value treated as transparent (no write).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-low.
start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
ROM_Q  in  24  ROM read data, valid the cycle after the ROM samples OE.
RAM_Q  in  24  RAM read data, valid the cycle after the RAM samples OE.
ROM_A  out  14  ROM address, y*128+x.
ROM_OE  out  1  ROM read enable.
RAM_A  out  16  RAM address, (Y_OFF+y)*256+(X_OFF+x).
RAM_WE  out  1  RAM write enable.
RAM_OE  out  1  RAM read enable.
RAM_D  out  24  RAM write data.
busy  out  1  high from the first RD cycle through the last pixel.
done  out  1  high after frame completion until the next accepted start or reset.

Behaviour:
- Memories are synchronous: A, OE, WE and D are sampled at the rising edge. Q is valid during the following cycle. All outputs are registered.
- Reset (rst=0 at an edge):
  - Next cycle: state IDLE, x=y=0, ROM_A=0, RAM_A=0, all enables 0, RAM_D=0, busy=0, done=0.
  - Reset overrides start and any in-progress pixel. An aborted write is never issued.
- FSM states:
  - IDLE: outputs quiescent. start=1 clears done and moves to RD.
  - RD: ROM_OE=RAM_OE=1, ROM_A and RAM_A for (x,y), busy=1. Always moves to WAIT.
  - WAIT: enables 0. ROM_Q and RAM_Q valid.
    - If ROM_Q==KEY_COLOR: advance the pixel counter, then go to RD (or DONE after the last pixel).
    - Otherwise: register the blend into RAM_D and go to WR.
  - WR: RAM_WE=1, RAM_A unchanged from RD, RAM_D = blend. Advance the counter, then go to RD (or DONE).
  - DONE: one cycle, busy=0, done set to 1. Moves to IDLE; done stays high.
- Latency: start sampled at edge k puts RD in cycle k+1 and WR in cycle k+3. Non-keyed pixel = 3 cycles; keyed pixel = 2 cycles.
- Blend, per channel c in {[23:16],[15:8],[7:0]}: out = (L*ALPHA + B*(16-ALPHA)) >> 4, where L = logo channel and B = background channel.
  - Products are 12-bit and the sum is 13-bit; truncate, no rounding.
  - ALPHA=16 gives exactly L; ALPHA=0 gives exactly B.
- Counter: x increments 0..127; at x=127 it wraps to 0 and y increments. The pixel at x=127, y=127 is last.
- Address arithmetic: RAM_A is computed 16 bits wide with no wrap (parameters are constrained so it cannot overflow).
- Corner cases:
  - start while busy or in DONE is ignored.
  - start held high in IDLE after done starts a new frame (done clears the next cycle).
  - ROM_OE/RAM_OE and RAM_WE are never high in the same cycle.

Test Plan:
1. Hold rst=0 for 2 edges with start=1 -> all outputs 0, busy=0, done=0; no memory access until rst=1 and a fresh start.
2. Defaults; ROM[0]=24'h204060, RAM[16448]=24'h000000; start at edge k -> cycle k+1: ROM_A=0, RAM_A=16448, both OE=1; cycle k+3: RAM_WE=1, RAM_D=24'h102030.
3. ROM[1]=24'hFFFFFF, RAM[16449]=24'h123456 -> no RAM_WE at address 16449, RAM[16449] still 24'h123456; the next RD (ROM_A=2) follows WAIT directly.
4. Full frame, no key pixels -> busy high for exactly 49152 cycles; last write at RAM_A=49087; done=1 the following cycle and held; RAM outside the window is unchanged.
5. ALPHA=16 run (logo copied exactly) and ALPHA=0 run (RAM unchanged) with random data; then reset at pixel 100 mid-WR -> no write that cycle, outputs 0; a new start restarts at ROM_A=0.
6. Pulse start during busy at pixel 50 -> ignored, frame completes normally with one done assertion.
